bcd_press_counter: RTL

BCD_PRESS_COUNTER -- requirements
Module: bcd_press_counter

---
 rtl/bcd_press_counter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bcd_press_counter.sv
// bcd_press_counter: counts debounced presses of an increment pushbutton as
// a packed multi-digit BCD value, with a debounced clear pushbutton.
// Both raw buttons are synchronised, debounced, and turned into one-cycle
// press strobes before they touch the count.

// Per-button synchroniser, debouncer and rising-edge (press) detector.
module bcd_press_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             db;
  logic             db_q;
  logic [CNT_W-1:0] cnt;

  // Synchronise the raw level, then accept a new level only after it has
  // differed from the debounced level for DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, matching real hardware.
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        // Input agrees with the accepted level (or bounced back): restart.
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Press is the debounced rising edge only; release edges are ignored.
  assign press = db & ~db_q;

endmodule

// Top level: two debounced buttons driving a BCD up-counter.
module bcd_press_counter #(
  parameter int DECIMAL_NUM     = 6,
  parameter int BCD_WIDTH       = DECIMAL_NUM * 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_inc,
  input  logic                 btn_clr,
  output logic [BCD_WIDTH-1:0] bcd_out,
  output logic                 inc_pulse,
  output logic                 wrap_pulse
);

  logic                 inc_press;
  logic                 clr_press;
  logic [BCD_WIDTH-1:0] bcd_next;
  logic                 all_nines;

  bcd_press_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_inc_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_inc),
    .press(inc_press)
  );

  bcd_press_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_clr),
    .press(clr_press)
  );

  // Ripple-carry BCD increment: 9 rolls to 0 and carries, everything above
  // the first non-9 digit holds; a carry out of the top digit means wrap.
  always_comb begin
    // NOTE: every output of this block is given a default before any
    // conditional update, so no path leaves a value unassigned (no latch).
    logic carry;
    bcd_next  = bcd_out;
    carry     = 1'b1;
    for (int i = 0; i < DECIMAL_NUM; i++) begin
      if (carry) begin
        if (bcd_out[4*i +: 4] == 4'd9) begin
          bcd_next[4*i +: 4] = 4'd0;
        end else begin
          bcd_next[4*i +: 4] = bcd_out[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  // Apply presses to the count; clear wins over a coincident increment,
  // which is dropped rather than held over.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_out    <= '0;
      inc_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      inc_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      if (clr_press) begin
        bcd_out <= '0;
      end else if (inc_press) begin
        bcd_out    <= bcd_next;
        inc_pulse  <= 1'b1;
        wrap_pulse <= all_nines;
      end
    end
  end

endmodule
